// File: rtl/axis_dc_filter_ctrl.sv
// Sequencer for the AXIS DC filter: quadrant strobe from the phase stream and IIR tau scheduling.
// Lock detection on the filtered DC value is compiled in when DC_FILTER_CTRL_LOCK_DETECT_EN is defined.
module axis_dc_filter_ctrl #(
  parameter int PHASE_WIDTH    = 32,
  parameter int ACQ_CNT_WIDTH  = 16,
  parameter int LOCK_CNT_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [PHASE_WIDTH-1:0]    S_AXIS_PHASE_tdata,
  input  logic                      S_AXIS_PHASE_tvalid,
  input  logic [1:0]                mode,
  input  logic                      restart,
  input  logic [31:0]               tau_fast,
  input  logic [31:0]               tau_slow,
  input  logic [ACQ_CNT_WIDTH-1:0]  acq_periods,
  input  logic [31:0]               dc_manual,
  input  logic [31:0]               mdc_in,
  input  logic [31:0]               lock_thresh,
  input  logic [LOCK_CNT_WIDTH-1:0] lock_periods,
  output logic                      sc_zero,
  output logic [31:0]               dc_tau,
  output logic [31:0]               dc,
  output logic                      locked,
  output logic [31:0]               status
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t                   state, state_next;
  logic [1:0]               quad;
  logic                     quad_loaded;
  logic [1:0]               qcnt;
  logic [ACQ_CNT_WIDTH-1:0] acq_cnt;
  logic [ACQ_CNT_WIDTH:0]   acq_cnt_inc;
  logic                     pulse;
  logic                     period_end;
  logic                     restart_clr;
  logic                     acq_done;
  logic [7:0]               lock_field;
  logic                     locked_bit;

  assign pulse       = S_AXIS_PHASE_tvalid && quad_loaded &&
                       (S_AXIS_PHASE_tdata[PHASE_WIDTH-1:PHASE_WIDTH-2] != quad);
  assign period_end  = pulse && (qcnt == 2'd3);
  assign restart_clr = restart && ((state == ST_ACQUIRE) || (state == ST_TRACK));
  assign acq_cnt_inc = {1'b0, acq_cnt} + {{ACQ_CNT_WIDTH{1'b0}}, 1'b1};
  assign acq_done    = (acq_cnt_inc >= {1'b0, acq_periods});

  // Next-state: per-state moves first, then mode overrides apply from any state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mode == 2'd1) state_next = ST_ACQUIRE;
        else              state_next = ST_IDLE;
      end
      ST_ACQUIRE: begin
        if (restart)                     state_next = ST_ACQUIRE;
        else if (period_end && acq_done) state_next = ST_TRACK;
        else                             state_next = ST_ACQUIRE;
      end
      ST_TRACK: begin
        if (restart) state_next = ST_ACQUIRE;
        else         state_next = ST_TRACK;
      end
      ST_HOLD: begin
        if (mode == 2'd1) state_next = ST_TRACK;
        else              state_next = ST_HOLD;
      end
      default: state_next = ST_IDLE;
    endcase
    if ((mode == 2'd0) || (mode == 2'd3)) state_next = ST_IDLE;
    else if (mode == 2'd2)                state_next = ST_HOLD;
    else                                  state_next = state_next;
  end

  // State, quadrant tracking and period/acquire counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      quad        <= 2'd0;
      quad_loaded <= 1'b0;
      qcnt        <= 2'd0;
      acq_cnt     <= {ACQ_CNT_WIDTH{1'b0}};
    end else begin
      state <= state_next;
      if (S_AXIS_PHASE_tvalid) begin
        quad        <= S_AXIS_PHASE_tdata[PHASE_WIDTH-1:PHASE_WIDTH-2];
        quad_loaded <= 1'b1;
      end
      if (restart_clr)  qcnt <= 2'd0;
      else if (pulse)   qcnt <= qcnt + 2'd1;
      if ((state_next != ST_ACQUIRE) || restart_clr)
        acq_cnt <= {ACQ_CNT_WIDTH{1'b0}};
      else if ((state == ST_ACQUIRE) && period_end)
        acq_cnt <= acq_cnt_inc[ACQ_CNT_WIDTH-1:0];
    end
  end

  // Filter-facing outputs follow the current state, so they lag a state change by one cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sc_zero <= 1'b0;
      dc_tau  <= 32'h8000_0000;
      dc      <= 32'h0000_0000;
    end else begin
      sc_zero <= pulse;
      dc      <= dc_manual;
      case (state)
        ST_IDLE:    dc_tau <= 32'h8000_0000;
        ST_ACQUIRE: dc_tau <= {1'b0, tau_fast[30:0]};
        ST_TRACK:   dc_tau <= {1'b0, tau_slow[30:0]};
        ST_HOLD:    dc_tau <= 32'h0000_0000;
        default:    dc_tau <= 32'h8000_0000;
      endcase
    end
  end

`ifdef DC_FILTER_CTRL_LOCK_DETECT_EN
  logic [LOCK_CNT_WIDTH-1:0] lock_cnt;
  logic [LOCK_CNT_WIDTH-1:0] lock_cnt_inc;
  logic                      locked_r;
  logic                      mdc_primed;
  logic [31:0]               mdc_prev;
  logic [32:0]               mdc_diff;
  logic [32:0]               mdc_abs;
  logic                      in_window;

  // 33-bit difference of sign-extended values never wraps; magnitude compared unsigned.
  always_comb begin
    mdc_diff     = {mdc_in[31], mdc_in} - {mdc_prev[31], mdc_prev};
    mdc_abs      = mdc_diff[32] ? (33'd0 - mdc_diff) : mdc_diff;
    in_window    = (mdc_abs <= {1'b0, lock_thresh});
    lock_cnt_inc = (&lock_cnt) ? lock_cnt : (lock_cnt + LOCK_CNT_WIDTH'(1));
  end

  // Lock qualification runs only while staying in TRACK; the first period end just primes mdc_prev.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lock_cnt   <= {LOCK_CNT_WIDTH{1'b0}};
      locked_r   <= 1'b0;
      mdc_primed <= 1'b0;
      mdc_prev   <= 32'h0000_0000;
    end else if ((state != ST_TRACK) || (state_next != ST_TRACK)) begin
      lock_cnt   <= {LOCK_CNT_WIDTH{1'b0}};
      locked_r   <= 1'b0;
      mdc_primed <= 1'b0;
    end else if (period_end) begin
      mdc_prev <= mdc_in;
      if (!mdc_primed) begin
        mdc_primed <= 1'b1;
        locked_r   <= (lock_cnt >= lock_periods);
      end else if (in_window) begin
        lock_cnt <= lock_cnt_inc;
        locked_r <= (lock_cnt_inc >= lock_periods);
      end else begin
        lock_cnt <= {LOCK_CNT_WIDTH{1'b0}};
        locked_r <= 1'b0;
      end
    end
  end

  assign locked_bit = locked_r;
  assign lock_field = 8'(lock_cnt);
`else
  assign locked_bit = 1'b0;
  assign lock_field = 8'd0;
`endif

  assign locked = locked_bit;
  assign status = {16'(acq_cnt), lock_field, 5'd0, locked_bit, state};

endmodule

// File: tb/tb_axis_dc_filter_ctrl.sv
// Directed self-checking bench for axis_dc_filter_ctrl (lock checks adapt to DC_FILTER_CTRL_LOCK_DETECT_EN).
module tb_axis_dc_filter_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] S_AXIS_PHASE_tdata;
  logic        S_AXIS_PHASE_tvalid;
  logic [1:0]  mode;
  logic        restart;
  logic [31:0] tau_fast;
  logic [31:0] tau_slow;
  logic [15:0] acq_periods;
  logic [31:0] dc_manual;
  logic [31:0] mdc_in;
  logic [31:0] lock_thresh;
  logic [7:0]  lock_periods;
  logic        sc_zero;
  logic [31:0] dc_tau;
  logic [31:0] dc;
  logic        locked;
  logic [31:0] status;

  int checks = 0;
  int failures = 0;
  logic [31:0] phase_idx;
  logic        exp_loaded;
  logic [1:0]  exp_quad;

  always #5 aclk = ~aclk;

  axis_dc_filter_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_PHASE_tdata(S_AXIS_PHASE_tdata), .S_AXIS_PHASE_tvalid(S_AXIS_PHASE_tvalid),
    .mode(mode), .restart(restart), .tau_fast(tau_fast), .tau_slow(tau_slow),
    .acq_periods(acq_periods), .dc_manual(dc_manual), .mdc_in(mdc_in),
    .lock_thresh(lock_thresh), .lock_periods(lock_periods),
    .sc_zero(sc_zero), .dc_tau(dc_tau), .dc(dc), .locked(locked), .status(status)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one sample and returns whether a quadrant strobe is expected for it.
  task automatic send(input logic [31:0] ph, input logic valid, output logic exp_p);
    logic [1:0] q;
    q = ph[31:30];
    S_AXIS_PHASE_tdata  = ph;
    S_AXIS_PHASE_tvalid = valid;
    exp_p = 1'b0;
    if (valid) begin
      if (exp_loaded && (q != exp_quad)) exp_p = 1'b1;
      exp_quad   = q;
      exp_loaded = 1'b1;
    end
    tick();
  endtask

  task automatic ramp_step(output logic exp_p);
    send(phase_idx << 28, 1'b1, exp_p);
    phase_idx = phase_idx + 32'd1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; mode = 2'd0; restart = 1'b0;
    S_AXIS_PHASE_tdata = 32'd0; S_AXIS_PHASE_tvalid = 1'b0;
    tau_fast = 32'h0100_0000; tau_slow = 32'h0001_0000; acq_periods = 16'd3;
    dc_manual = 32'h0040_0000; mdc_in = 32'd0; lock_thresh = 32'd16; lock_periods = 8'd4;
    tick(); tick();
    checks++; if (sc_zero !== 1'b0) begin failures++; $display("FAIL reset_sc_zero got=%h exp=0", sc_zero); end
    checks++; if (dc_tau !== 32'h8000_0000) begin failures++; $display("FAIL reset_dc_tau got=%h exp=80000000", dc_tau); end
    checks++; if (dc !== 32'h0) begin failures++; $display("FAIL reset_dc got=%h exp=0", dc); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%h exp=0", locked); end
    checks++; if (status !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", status); end
    aresetn = 1'b1; exp_loaded = 1'b0; exp_quad = 2'd0;
  endtask

  task automatic test_ramp();
    logic e;
    phase_idx = 32'd0;
    for (int i = 0; i < 20; i++) begin
      ramp_step(e);
      checks++;
      if (sc_zero !== e) begin failures++; $display("FAIL ramp_sc_zero i=%0d got=%b exp=%b", i, sc_zero, e); end
    end
    checks++; if (dc_tau !== 32'h8000_0000) begin failures++; $display("FAIL manual_dc_tau got=%h exp=80000000", dc_tau); end
    checks++; if (dc !== 32'h0040_0000) begin failures++; $display("FAIL manual_dc got=%h exp=00400000", dc); end
    S_AXIS_PHASE_tvalid = 1'b0;
  endtask

  task automatic test_acquire();
    logic e;
    int npulse;
    mode = 2'd1; S_AXIS_PHASE_tvalid = 1'b0;
    tick();
    checks++; if (status[1:0] !== 2'd1) begin failures++; $display("FAIL acq_state got=%0d exp=1", status[1:0]); end
    checks++; if (dc_tau !== 32'h8000_0000) begin failures++; $display("FAIL acq_tau_latency got=%h exp=80000000", dc_tau); end
    restart = 1'b1; tick(); restart = 1'b0;
    checks++; if (dc_tau !== 32'h0100_0000) begin failures++; $display("FAIL acq_tau_start got=%h exp=01000000", dc_tau); end
    npulse = 0;
    for (int i = 0; i < 100 && npulse < 12; i++) begin
      ramp_step(e);
      if (e) npulse++;
      checks++;
      if (sc_zero !== e) begin failures++; $display("FAIL acq_sc_zero i=%0d got=%b exp=%b", i, sc_zero, e); end
      checks++;
      if (dc_tau !== 32'h0100_0000) begin failures++; $display("FAIL acq_dc_tau pulse=%0d got=%h exp=01000000", npulse, dc_tau); end
      if (e && npulse == 8) begin
        checks++;
        if (status[31:16] !== 16'd2) begin failures++; $display("FAIL acq_cnt got=%0d exp=2", status[31:16]); end
      end
    end
    checks++; if (npulse != 12) begin failures++; $display("FAIL acq_timeout got=%0d exp=12", npulse); end
    S_AXIS_PHASE_tvalid = 1'b0;
    tick();
    checks++; if (dc_tau !== 32'h0001_0000) begin failures++; $display("FAIL track_dc_tau got=%h exp=00010000", dc_tau); end
    checks++; if (status[1:0] !== 2'd2) begin failures++; $display("FAIL track_state got=%0d exp=2", status[1:0]); end
    checks++; if (status[31:16] !== 16'd0) begin failures++; $display("FAIL track_acq_cnt got=%0d exp=0", status[31:16]); end
  endtask

  task automatic test_lock();
    logic e;
    int cnt;
    logic exp_locked;
    logic [7:0] exp_cnt;
    mdc_in = 32'hFFFF_FFD8;
    for (int p = 1; p <= 6; p++) begin
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 4; i++) begin
        ramp_step(e);
        if (e) cnt++;
      end
      checks++; if (cnt != 4) begin failures++; $display("FAIL lock_period_timeout p=%0d got=%0d exp=4", p, cnt); end
`ifdef DC_FILTER_CTRL_LOCK_DETECT_EN
      exp_locked = (p == 5);
      exp_cnt    = (p <= 5) ? 8'(p - 1) : 8'd0;
`else
      exp_locked = 1'b0;
      exp_cnt    = 8'd0;
`endif
      checks++; if (locked !== exp_locked) begin failures++; $display("FAIL lock_flag p=%0d got=%b exp=%b", p, locked, exp_locked); end
      checks++; if (status[15:8] !== exp_cnt) begin failures++; $display("FAIL lock_cnt p=%0d got=%0d exp=%0d", p, status[15:8], exp_cnt); end
      checks++; if (status[2] !== exp_locked) begin failures++; $display("FAIL lock_status_bit p=%0d got=%b exp=%b", p, status[2], exp_locked); end
      if (p < 5) mdc_in = mdc_in + 32'd8;
      else       mdc_in = mdc_in + 32'd100;
    end
    S_AXIS_PHASE_tvalid = 1'b0;
  endtask

  task automatic test_restart();
    restart = 1'b1; tick(); restart = 1'b0;
    checks++; if (status[1:0] !== 2'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", status[1:0]); end
    checks++; if (status[31:16] !== 16'd0) begin failures++; $display("FAIL restart_acq_cnt got=%0d exp=0", status[31:16]); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL restart_locked got=%b exp=0", locked); end
    checks++; if (status[15:8] !== 8'd0) begin failures++; $display("FAIL restart_lock_cnt got=%0d exp=0", status[15:8]); end
  endtask

  task automatic test_tau_mask();
    tau_fast = 32'hFFFF_FFFF;
    tick();
    checks++; if (dc_tau !== 32'h7FFF_FFFF) begin failures++; $display("FAIL tau_mask got=%h exp=7fffffff", dc_tau); end
  endtask

  task automatic test_hold();
    mode = 2'd2; tick();
    checks++; if (status[1:0] !== 2'd3) begin failures++; $display("FAIL hold_state got=%0d exp=3", status[1:0]); end
    tick();
    checks++; if (dc_tau !== 32'h0) begin failures++; $display("FAIL hold_dc_tau got=%h exp=0", dc_tau); end
    restart = 1'b1; tick(); restart = 1'b0;
    checks++; if (status[1:0] !== 2'd3) begin failures++; $display("FAIL hold_restart_ignored got=%0d exp=3", status[1:0]); end
    mode = 2'd1; tick();
    checks++; if (status[1:0] !== 2'd2) begin failures++; $display("FAIL hold_to_track got=%0d exp=2", status[1:0]); end
    tick();
    checks++; if (dc_tau !== 32'h0001_0000) begin failures++; $display("FAIL hold_track_tau got=%h exp=00010000", dc_tau); end
  endtask

  task automatic test_jump();
    logic e;
    logic [31:0] ph;
    ph = ((phase_idx - 32'd1) << 28) + 32'h8000_0000;
    send(ph, 1'b1, e);
    checks++; if (sc_zero !== 1'b1) begin failures++; $display("FAIL jump_pulse got=%b exp=1", sc_zero); end
    for (int i = 0; i < 10; i++) begin
      send(32'(i) << 29, 1'b0, e);
      checks++; if (sc_zero !== 1'b0) begin failures++; $display("FAIL invalid_no_pulse i=%0d got=%b exp=0", i, sc_zero); end
    end
    send(ph, 1'b1, e);
    checks++; if (sc_zero !== 1'b0) begin failures++; $display("FAIL same_quad_no_pulse got=%b exp=0", sc_zero); end
    S_AXIS_PHASE_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid_track();
    logic e;
    checks++; if (status[1:0] !== 2'd2) begin failures++; $display("FAIL pre_reset_state got=%0d exp=2", status[1:0]); end
    S_AXIS_PHASE_tdata = S_AXIS_PHASE_tdata + 32'h4000_0000;
    S_AXIS_PHASE_tvalid = 1'b1;
    aresetn = 1'b0;
    tick();
    checks++; if (sc_zero !== 1'b0) begin failures++; $display("FAIL rst2_sc_zero got=%b exp=0", sc_zero); end
    checks++; if (dc_tau !== 32'h8000_0000) begin failures++; $display("FAIL rst2_dc_tau got=%h exp=80000000", dc_tau); end
    checks++; if (dc !== 32'h0) begin failures++; $display("FAIL rst2_dc got=%h exp=0", dc); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst2_locked got=%b exp=0", locked); end
    checks++; if (status !== 32'h0) begin failures++; $display("FAIL rst2_status got=%h exp=0", status); end
    aresetn = 1'b1; exp_loaded = 1'b0; exp_quad = 2'd0;
    send(32'hC000_0000, 1'b1, e);
    checks++; if (sc_zero !== 1'b0) begin failures++; $display("FAIL first_sample_no_pulse got=%b exp=0", sc_zero); end
    send(32'h1000_0000, 1'b1, e);
    checks++; if (sc_zero !== 1'b1) begin failures++; $display("FAIL post_reset_pulse got=%b exp=1", sc_zero); end
    S_AXIS_PHASE_tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_acquire();
    test_lock();
    test_restart();
    test_tau_mask();
    test_hold();
    test_jump();
    test_reset_mid_track();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
